// File: rtl/cic_upsampler.sv
// cic_upsampler: CIC rate expander; each accepted low-rate sample becomes R high-rate samples
//   (zero-stuffed, or repeated when HOLD_MODE=1).
// Latency: 1 clock from input accept to first out_valid; bursts chain back-to-back with no gap.
// Backpressure: out_ready=0 freezes phase, sample and d_out; the next input is taken only on the
//   final-phase transfer, so upstream holds in_valid/d_in until in_ready.
// Ports: clk, rst (sync, active-high) | d_in/in_valid/in_ready (low-rate side) |
//   d_out/out_valid/out_ready (high-rate side) | out_first (phase 0 marker), out_phase (0..R-1).
module cic_upsampler #(
  parameter int R          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int HOLD_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic [7:0]            out_phase
);

  localparam logic [7:0] LAST_PHASE = 8'(R - 1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              p_q, p_d;
  logic [DATA_WIDTH-1:0]   s_q, s_d;
  logic                    last_phase;

  assign last_phase = (p_q == LAST_PHASE);

  // Combinational ready lets the next sample load on the same edge that
  // retires the final phase, so a continuous stream never drops out_valid.
  assign in_ready = !rst && ((state_q == IDLE) ||
                             (state_q == EMIT && out_ready && last_phase));

  // Outputs are decoded from registers only; rst masks them so a reset
  // cycle never presents a stale sample.
  always_comb begin
    out_valid = 1'b0;
    d_out     = '0;
    out_phase = 8'd0;
    if (!rst && state_q == EMIT) begin
      out_valid = 1'b1;
      out_phase = p_q;
      if (p_q == 8'd0 || HOLD_MODE != 0) begin
        d_out = s_q;
      end
    end
  end

  assign out_first = out_valid && (out_phase == 8'd0);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          s_d     = d_in;
          p_d     = 8'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_phase) begin
            p_d = p_q + 8'd1;
          end else if (in_valid) begin
            s_d = d_in;
            p_d = 8'd0;
          end else begin
            p_d     = 8'd0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 8'd0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_cic_upsampler.sv
// Directed bench for cic_upsampler: a zero-stuff R=4 instance and a hold-mode R=3 instance
// share clock and reset. Inputs change just after each falling edge; outputs are checked
// 1 time unit later, well away from the rising edge.
module tb_cic_upsampler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic [7:0]  out_phase;

  logic [31:0] h_d_in;
  logic        h_in_valid;
  logic        h_in_ready;
  logic [31:0] h_d_out;
  logic        h_out_valid;
  logic        h_out_ready;
  logic        h_out_first;
  logic [7:0]  h_out_phase;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cic_upsampler #(.R(4), .DATA_WIDTH(32), .HOLD_MODE(0)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready),
    .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_phase(out_phase)
  );

  cic_upsampler #(.R(3), .DATA_WIDTH(32), .HOLD_MODE(1)) dut_hold (
    .clk(clk), .rst(rst), .d_in(h_d_in), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .d_out(h_d_out), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_first(h_out_first), .out_phase(h_out_phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Sample view of zero-stuff instance in one call.
  task automatic check_out(input string tag, input logic vld, input logic [31:0] dat,
                           input logic first, input logic [7:0] ph);
    check({tag, ".valid"}, 32'(out_valid), 32'(vld));
    check({tag, ".data"},  d_out, dat);
    check({tag, ".first"}, 32'(out_first), 32'(first));
    check({tag, ".phase"}, 32'(out_phase), 32'(ph));
  endtask

  logic [31:0] vals [4];

  initial begin
    vals[0] = 32'd5;
    vals[1] = 32'hFFFF_FFF9;   // -7
    vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h8000_0000;

    // Reset held 3 cycles with input offered
    rst = 1'b1; in_valid = 1'b1; d_in = 32'd55; out_ready = 1'b1;
    h_in_valid = 1'b0; h_d_in = 32'd0; h_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.data", d_out, 32'd0);
      check("rst.phase", 32'(out_phase), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("idle.in_ready", 32'(in_ready), 32'd1);
    check("idle.valid", 32'(out_valid), 32'd0);
    check("idle.hold_in_ready", 32'(h_in_ready), 32'd1);

    // Zero-stuff burst of 100
    in_valid = 1'b1; d_in = 32'd100;
    #1 check("zs.accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; d_in = 32'd0;
    #1 check_out("zs.p0", 1'b1, 32'd100, 1'b1, 8'd0);
    tick(); check_out("zs.p1", 1'b1, 32'd0, 1'b0, 8'd1);
    check("zs.p1_ready", 32'(in_ready), 32'd0);
    tick(); check_out("zs.p2", 1'b1, 32'd0, 1'b0, 8'd2);
    tick(); check_out("zs.p3", 1'b1, 32'd0, 1'b0, 8'd3);
    check("zs.p3_ready", 32'(in_ready), 32'd1);
    tick(); check("zs.end_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream of four samples including both extremes
    in_valid = 1'b1; d_in = vals[0];
    tick();
    for (int c = 0; c < 16; c++) begin
      if (c < 15) d_in = vals[c/4 + 1 > 3 ? 3 : c/4 + 1];
      else in_valid = 1'b0;
      #1;
      check_out($sformatf("b2b.c%0d", c), 1'b1, (c % 4 == 0) ? vals[c/4] : 32'd0,
                (c % 4 == 0), 8'(c % 4));
      check($sformatf("b2b.ready%0d", c), 32'(in_ready), 32'((c % 4) == 3));
      tick();
    end
    check("b2b.end_valid", 32'(out_valid), 32'd0);

    // Backpressure at phase 2 of a burst of 42, next sample 9 waiting
    in_valid = 1'b1; d_in = 32'd42;
    tick();
    d_in = 32'd9;
    #1 check_out("bp.p0", 1'b1, 32'd42, 1'b1, 8'd0);
    check("bp.p0_ready", 32'(in_ready), 32'd0);
    tick(); check("bp.p1_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_out($sformatf("bp.stall%0d", i), 1'b1, 32'd0, 1'b0, 8'd2);
      check($sformatf("bp.stall_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp.rel_phase", 32'(out_phase), 32'd2);
    check("bp.rel_ready", 32'(in_ready), 32'd0);
    tick(); check_out("bp.p3", 1'b1, 32'd0, 1'b0, 8'd3);
    check("bp.p3_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #1 check("bp.p3_stall_ready", 32'(in_ready), 32'd0);
    tick(); check("bp.p3_stall_phase", 32'(out_phase), 32'd3);
    out_ready = 1'b1;
    #1 check("bp.p3_go_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1 check_out("bp.next_p0", 1'b1, 32'd9, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    check("bp.end_valid", 32'(out_valid), 32'd0);

    // Reset mid-burst of 77
    in_valid = 1'b1; d_in = 32'd77;
    tick();
    in_valid = 1'b0;
    #1 check_out("mr.p0", 1'b1, 32'd77, 1'b1, 8'd0);
    tick(); check("mr.p1_phase", 32'(out_phase), 32'd1);
    rst = 1'b1;
    tick();
    check_out("mr.rst", 1'b0, 32'd0, 1'b0, 8'd0);
    rst = 1'b0;
    tick();
    check_out("mr.after", 1'b0, 32'd0, 1'b0, 8'd0);
    in_valid = 1'b1; d_in = 32'd3;
    #1 check("mr.accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1 check_out("mr.q0", 1'b1, 32'd3, 1'b1, 8'd0);
    tick(); check_out("mr.q1", 1'b1, 32'd0, 1'b0, 8'd1);
    tick(); check_out("mr.q2", 1'b1, 32'd0, 1'b0, 8'd2);
    tick(); check_out("mr.q3", 1'b1, 32'd0, 1'b0, 8'd3);
    tick(); check("mr.end_valid", 32'(out_valid), 32'd0);

    // Hold mode, R=3: -9 repeated three times
    h_in_valid = 1'b1; h_d_in = 32'hFFFF_FFF7;
    tick();
    h_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold.valid%0d", i), 32'(h_out_valid), 32'd1);
      check($sformatf("hold.data%0d", i), h_d_out, 32'hFFFF_FFF7);
      check($sformatf("hold.first%0d", i), 32'(h_out_first), 32'(i == 0));
      check($sformatf("hold.phase%0d", i), 32'(h_out_phase), 32'(i));
      tick();
    end
    check("hold.end_valid", 32'(h_out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
